// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI state encoding and default frame width
package spi_pkg;

  localparam int SPI_WIDTH = 13;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_LATCH,
    S_DONE
  } spi_state_t;

  // Phases that last CLK_DIV cycles and keep the frame busy.
  function automatic logic phase_timed(spi_state_t s);
    return s inside {S_LOAD, S_SETUP, S_HIGH, S_LOW, S_LATCH};
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - user word handshake plus SPI pin bundle for spi_master
interface spi_master_if import spi_pkg::*; #(
  parameter int WIDTH = SPI_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] tx_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rx_data;
  logic             sclk;
  logic             load;
  logic             mosi;
  logic             miso;

  modport master (
    input  start, tx_data, miso,
    output busy, done, rx_data, sclk, load, mosi
  );

  modport slave (
    output start, tx_data, miso,
    input  busy, done, rx_data, sclk, load, mosi
  );

endinterface

// File: rtl/spi_tick_gen.sv
// rtl/spi_tick_gen.sv - half-period counter, tick on the last cycle of each phase
module spi_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int            CW   = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Wrapping keeps consecutive phases aligned without a reload cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (!en || cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI master framing WIDTH-bit words between load pulses
module spi_master import spi_pkg::*; #(
  parameter int WIDTH   = SPI_WIDTH,
  parameter int CLK_DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  spi_master_if.master bus
);

  localparam int            BW       = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  spi_state_t       state_q, state_d;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             sclk_q, sclk_d;
  logic             load_q, load_d;
  logic             mosi_q, mosi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timed_en;
  logic             tick;

  assign timed_en = phase_timed(state_q);

  spi_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (timed_en),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_LOAD;
      S_LOAD:  if (tick) state_d = S_SETUP;
      S_SETUP: if (tick) state_d = S_HIGH;
      S_HIGH:  if (tick) state_d = (bit_cnt_q == LAST_BIT) ? S_LATCH : S_LOW;
      S_LOW:   if (tick) state_d = S_HIGH;
      S_LATCH: if (tick) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pin outputs are decoded from the next state so they register in step with it.
  always_comb begin
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    if (state_q == S_IDLE && bus.start) begin
      tx_sr_d   = bus.tx_data;
      bit_cnt_d = '0;
    end
    if (state_q == S_HIGH && tick) begin
      rx_sr_d = {rx_sr_q[WIDTH-2:0], bus.miso};
      if (bit_cnt_q != LAST_BIT) begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
    if (state_q == S_HIGH && state_d == S_LOW) begin
      tx_sr_d = tx_sr_q << 1;
    end
    if (state_d == S_DONE) begin
      rx_data_d = rx_sr_q;
    end
    sclk_d = (state_d == S_HIGH);
    load_d = (state_d == S_LOAD) || (state_d == S_LATCH);
    busy_d = phase_timed(state_d);
    done_d = (state_d == S_DONE);
    mosi_d = (state_d inside {S_LOAD, S_SETUP, S_HIGH, S_LOW}) ? tx_sr_d[WIDTH-1] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      sclk_q    <= 1'b0;
      load_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
      load_q    <= load_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.sclk    = sclk_q;
  assign bus.load    = load_q;
  assign bus.mosi    = mosi_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - bench for spi_master at CLK_DIV 4 and 1 with loopback and slave model
module tb_spi_master;
  import spi_pkg::*;

  localparam int W = SPI_WIDTH;
  localparam int LAT4 = (2 * W + 2) * 4;
  localparam int LAT1 = (2 * W + 2) * 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_master_if #(.WIDTH(W)) if4 ();
  spi_master_if #(.WIDTH(W)) if1 ();

  spi_master #(.WIDTH(W), .CLK_DIV(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.master));
  spi_master #(.WIDTH(W), .CLK_DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.master));

  logic         sel = 1'b0;
  logic         start_v = 1'b0;
  logic         lb4 = 1'b1;
  logic [W-1:0] tx_v = '0;
  logic [W-1:0] sl_din = '0;
  logic [W-1:0] sl_sr = '0;
  logic [W-1:0] sl_rx = '0;
  logic [W-1:0] sl_dout = '0;
  logic         sl_pl = 1'b0;
  logic         sl_ps = 1'b0;
  int           n_cmp = 0;
  int           n_bad = 0;

  assign if4.start   = start_v & ~sel;
  assign if1.start   = start_v & sel;
  assign if4.tx_data = tx_v;
  assign if1.tx_data = tx_v;
  assign if4.miso    = lb4 ? if4.mosi : sl_sr[W-1];
  assign if1.miso    = if1.mosi;

  wire         m_busy = sel ? if1.busy : if4.busy;
  wire         m_done = sel ? if1.done : if4.done;
  wire         m_sclk = sel ? if1.sclk : if4.sclk;
  wire         m_load = sel ? if1.load : if4.load;
  wire         m_mosi = sel ? if1.mosi : if4.mosi;
  wire [W-1:0] m_rx   = sel ? if1.rx_data : if4.rx_data;

  // Behavioural slave: load rise latches dout and reloads din, sclk rise samples, fall shifts.
  always @(if4.load or if4.sclk) begin
    if (if4.load && !sl_pl) begin
      sl_dout = sl_rx;
      sl_sr   = sl_din;
    end
    if (if4.sclk && !sl_ps) sl_rx = {sl_rx[W-2:0], if4.mosi};
    if (!if4.sclk && sl_ps) sl_sr = sl_sr << 1;
    sl_pl = if4.load;
    sl_ps = if4.sclk;
  end

  task automatic run_frame(input bit use1, input logic [W-1:0] tx, input bit hold,
                           output logic [W-1:0] rx, output int lat, output int gap,
                           output int rises, output int load_cyc, output int load_pulses,
                           output int mosi_hi, output int mosi_last, output bit busy_at_done);
    bit ps = 1'b0;
    bit pl = 1'b0;
    sel = use1;
    tx_v = tx;
    start_v = 1'b1;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!m_busy && gap < 20);
    if (!hold) start_v = 1'b0;
    lat = -1; rises = 0; load_cyc = 0; load_pulses = 0; mosi_hi = 0; mosi_last = -1;
    busy_at_done = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (k > 0) @(negedge clk);
      if (hold) tx_v = W'($urandom);
      if (m_sclk && !ps) rises++;
      if (m_load) begin
        load_cyc++;
        if (!pl) load_pulses++;
      end
      if (m_mosi) begin
        mosi_hi++;
        mosi_last = k;
      end
      ps = m_sclk;
      pl = m_load;
      if (m_done) begin
        lat = k;
        busy_at_done = m_busy;
        break;
      end
    end
    rx = m_rx;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({if4.sclk, if4.load, if4.mosi, if4.busy, if4.done} !== 5'b0) begin
      n_bad++; $display("FAIL reset_pins4: got %b expected 00000", {if4.sclk, if4.load, if4.mosi, if4.busy, if4.done});
    end
    n_cmp++;
    if (if4.rx_data !== '0) begin
      n_bad++; $display("FAIL reset_rx4: got %h expected 0", if4.rx_data);
    end
    n_cmp++;
    if ({if1.sclk, if1.load, if1.mosi, if1.busy, if1.done, if1.rx_data} !== '0) begin
      n_bad++; $display("FAIL reset_dut1: got %b expected 0", {if1.sclk, if1.load, if1.mosi, if1.busy, if1.done, if1.rx_data});
    end
    rst = 1'b0;
  endtask

  task automatic test_loopback();
    logic [W-1:0] rx, tx;
    int lat, gap, rises, lc, lp, mh, ml;
    bit bd;
    lb4 = 1'b1;
    run_frame(1'b0, 13'h1234, 1'b0, rx, lat, gap, rises, lc, lp, mh, ml, bd);
    n_cmp++; if (rx !== 13'h1234) begin n_bad++; $display("FAIL lb_rx: got %h expected 1234", rx); end
    n_cmp++; if (lat !== LAT4) begin n_bad++; $display("FAIL lb_latency: got %0d expected %0d", lat, LAT4); end
    n_cmp++; if (rises !== W) begin n_bad++; $display("FAIL lb_sclk_rises: got %0d expected %0d", rises, W); end
    n_cmp++; if (lp !== 2) begin n_bad++; $display("FAIL lb_load_pulses: got %0d expected 2", lp); end
    n_cmp++; if (lc !== 8) begin n_bad++; $display("FAIL lb_load_cycles: got %0d expected 8", lc); end
    n_cmp++; if (bd !== 1'b0) begin n_bad++; $display("FAIL lb_busy_at_done: got %b expected 0", bd); end
    for (int i = 0; i < 3; i++) begin
      tx = W'($urandom);
      run_frame(1'b0, tx, 1'b0, rx, lat, gap, rises, lc, lp, mh, ml, bd);
      n_cmp++; if (rx !== tx || lat !== LAT4) begin
        n_bad++; $display("FAIL lb_rand: got %h/%0d expected %h/%0d", rx, lat, tx, LAT4);
      end
    end
  endtask

  task automatic test_slave();
    logic [W-1:0] rx, tx;
    int lat, gap, rises, lc, lp, mh, ml;
    bit bd;
    lb4 = 1'b0;
    sl_din = 13'h0A5A;
    run_frame(1'b0, 13'h1F01, 1'b0, rx, lat, gap, rises, lc, lp, mh, ml, bd);
    n_cmp++; if (rx !== 13'h0A5A) begin n_bad++; $display("FAIL slv_rx: got %h expected 0a5a", rx); end
    n_cmp++; if (sl_dout !== 13'h1F01) begin n_bad++; $display("FAIL slv_dout: got %h expected 1f01", sl_dout); end
    for (int i = 0; i < 2; i++) begin
      sl_din = W'($urandom);
      tx = W'($urandom);
      run_frame(1'b0, tx, 1'b0, rx, lat, gap, rises, lc, lp, mh, ml, bd);
      n_cmp++; if (rx !== sl_din || sl_dout !== tx) begin
        n_bad++; $display("FAIL slv_rand: got %h/%h expected %h/%h", rx, sl_dout, sl_din, tx);
      end
    end
    lb4 = 1'b1;
  endtask

  task automatic test_bit_order();
    logic [W-1:0] rx;
    int lat, gap, rises, lc, lp, mh, ml;
    bit bd;
    lb4 = 1'b1;
    run_frame(1'b0, 13'h1000, 1'b0, rx, lat, gap, rises, lc, lp, mh, ml, bd);
    // MSB is presented through LOAD, SETUP and the first HIGH phase only.
    n_cmp++; if (mh !== 3 * 4 || ml !== 3 * 4 - 1) begin
      n_bad++; $display("FAIL bit_order_mosi: got %0d cycles last %0d expected 12 last 11", mh, ml);
    end
    n_cmp++; if (m_mosi !== 1'b0) begin n_bad++; $display("FAIL bit_order_done_mosi: got %b expected 0", m_mosi); end
    @(negedge clk);
    n_cmp++; if (m_mosi !== 1'b0 || m_busy !== 1'b0) begin
      n_bad++; $display("FAIL bit_order_idle: got mosi %b busy %b expected 0 0", m_mosi, m_busy);
    end
    n_cmp++; if (rx !== 13'h1000) begin n_bad++; $display("FAIL bit_order_rx: got %h expected 1000", rx); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] rx, tx;
    int lat, gap, rises, lc, lp, mh, ml;
    bit bd;
    sel = 1'b0;
    lb4 = 1'b0;
    sl_din = W'($urandom);
    tx_v = W'($urandom);
    start_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0;
    repeat (40) @(negedge clk);
    n_cmp++; if (if4.busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b expected 1", if4.busy); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if ({if4.sclk, if4.load, if4.mosi, if4.busy, if4.done, if4.rx_data} !== '0) begin
      n_bad++; $display("FAIL mid_reset: got %b expected 0", {if4.sclk, if4.load, if4.mosi, if4.busy, if4.done, if4.rx_data});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if ({if4.busy, if4.rx_data} !== '0) begin
      n_bad++; $display("FAIL mid_after: got %b expected 0", {if4.busy, if4.rx_data});
    end
    tx = W'($urandom);
    run_frame(1'b0, tx, 1'b0, rx, lat, gap, rises, lc, lp, mh, ml, bd);
    n_cmp++; if (rx !== sl_din || sl_dout !== tx || lat !== LAT4) begin
      n_bad++; $display("FAIL mid_recover: got %h/%h/%0d expected %h/%h/%0d", rx, sl_dout, lat, sl_din, tx, LAT4);
    end
    lb4 = 1'b1;
  endtask

  task automatic test_start_held();
    logic [W-1:0] rx, a, b;
    int lat, gap, rises, lc, lp, mh, ml;
    bit bd;
    lb4 = 1'b1;
    @(negedge clk);
    a = W'($urandom);
    b = W'($urandom);
    run_frame(1'b0, a, 1'b1, rx, lat, gap, rises, lc, lp, mh, ml, bd);
    n_cmp++; if (rx !== a || lat !== LAT4 || gap !== 1) begin
      n_bad++; $display("FAIL held_first: got %h/%0d/%0d expected %h/%0d/1", rx, lat, gap, a, LAT4);
    end
    run_frame(1'b0, b, 1'b1, rx, lat, gap, rises, lc, lp, mh, ml, bd);
    n_cmp++; if (gap !== 2) begin n_bad++; $display("FAIL held_gap: got %0d expected 2", gap); end
    n_cmp++; if (rx !== b || lat !== LAT4) begin
      n_bad++; $display("FAIL held_second: got %h/%0d expected %h/%0d", rx, lat, b, LAT4);
    end
    start_v = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (m_busy !== 1'b0 || m_rx !== b) begin
      n_bad++; $display("FAIL held_stop: got busy %b rx %h expected 0 %h", m_busy, m_rx, b);
    end
  endtask

  task automatic test_back_to_back_div1();
    logic [W-1:0] rx, tx;
    int lat, gap, rises, lc, lp, mh, ml;
    bit bd;
    run_frame(1'b1, 13'h1FFF, 1'b0, rx, lat, gap, rises, lc, lp, mh, ml, bd);
    n_cmp++; if (rx !== 13'h1FFF || lat !== LAT1 || rises !== W) begin
      n_bad++; $display("FAIL div1_ones: got %h/%0d/%0d expected 1fff/%0d/%0d", rx, lat, rises, LAT1, W);
    end
    run_frame(1'b1, 13'h0000, 1'b0, rx, lat, gap, rises, lc, lp, mh, ml, bd);
    n_cmp++; if (rx !== 13'h0000 || lat !== LAT1 || gap !== 2) begin
      n_bad++; $display("FAIL div1_zeros: got %h/%0d/%0d expected 0000/%0d/2", rx, lat, gap, LAT1);
    end
    for (int i = 0; i < 4; i++) begin
      tx = W'($urandom);
      run_frame(1'b1, tx, 1'b0, rx, lat, gap, rises, lc, lp, mh, ml, bd);
      n_cmp++; if (rx !== tx || lat !== LAT1 || lc !== 2) begin
        n_bad++; $display("FAIL div1_rand: got %h/%0d/%0d expected %h/%0d/2", rx, lat, lc, tx, LAT1);
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_loopback();
    test_slave();
    test_bit_order();
    test_reset_mid();
    test_start_held();
    test_back_to_back_div1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
